// File: rtl/ev21g1_pkg.sv
// ev21g1_pkg: shared types and constants for the EV21G1 microsequencer.
// Holds the sequencer opcode encoding, the control-word layout and the
// data-path NOP word.
package ev21g1_pkg;

   localparam int MI_W      = 30;
   localparam int K_W       = 16;
   localparam int CW_W      = 49;
   localparam int OP_W      = 3;

   // Control-word layout: [48:46] seq op, [45:30] k, [29:0] microinstruction
   localparam int CW_MI_LSB = 0;
   localparam int CW_K_LSB  = 30;
   localparam int CW_OP_LSB = 46;

   // Microinstruction field holding the data-path function select (c)
   localparam int MI_C_LSB  = 2;
   localparam int MI_C_W    = 6;

   localparam int USTACK_DEPTH = 4;

   typedef enum logic [OP_W-1:0] {
      OP_CONT = 3'd0,
      OP_JUMP = 3'd1,
      OP_JZ   = 3'd2,
      OP_JC   = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5,
      OP_HALT = 3'd6,
      OP_RSVD = 3'd7
   } seq_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   // NOP: every field zero except c = all ones (30'h000000FC)
   localparam logic [MI_W-1:0] NOP_MI = {{(MI_W-MI_C_LSB-MI_C_W){1'b0}},
                                        {MI_C_W{1'b1}},
                                        {MI_C_LSB{1'b0}}};
   localparam logic [K_W-1:0]  NOP_K  = '0;

   function automatic seq_op_e cw_op(input logic [CW_W-1:0] cw);
      return seq_op_e'(cw[CW_OP_LSB +: OP_W]);
   endfunction

endpackage

// File: rtl/ev21g1_microsequencer_ustack.sv
// ev21g1_ustack: small circular return-address stack.
// A push when full overwrites the oldest entry; pop when empty is a no-op.
// DEPTH must be a power of two so the write pointer wraps naturally.
module ev21g1_ustack #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [PW-1:0] top;

   assign top   = wp_q - PW'(1);
   assign dout  = mem_q[top];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (PW+1)'(DEPTH));

   // Pointer/occupancy update; the count saturates so the oldest slot is reused
   always_comb begin
      wp_d  = wp_q;
      cnt_d = cnt_q;
      if (push) begin
         wp_d = wp_q + PW'(1);
         if (!full) cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop && !empty) begin
         wp_d  = top;
         cnt_d = cnt_q - (PW+1)'(1);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents need no reset since occupancy gates their use
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= din;
   end

endmodule

// File: rtl/ev21g1_microsequencer.sv
// ev21g1_microsequencer: micro-PC sequencer driving an asynchronous control
// store and feeding registered microinstruction/k words to the data path.
// Conditional branches insert STALL_N NOP bubbles and resolve on the last one.
// Optional build macro: EV21G1_USTACK_EN enables CALL/RET through a 4-entry
// circular return stack; without it CALL acts as JUMP and RET as CONT.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | after reset; emits NOP, waits for start
// ST_RUN   | fetches cs_data every cycle and sequences the micro-PC
// ST_STALL | conditional branch pending; emits NOPs, resolves on last cycle
// ST_HALT  | stopped by HALT op (or RET on empty stack); emits NOP
module ev21g1_microsequencer
   import ev21g1_pkg::*;
#(
   parameter int UPC_W   = 10,
   parameter int STALL_N = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [UPC_W-1:0] cs_addr,
   input  logic [CW_W-1:0]  cs_data,
   input  logic             zero_flag,
   input  logic             carry_flag,
   output logic [MI_W-1:0]  microinstruction,
   output logic [K_W-1:0]   k,
   output logic             halted
);
   localparam int              SC_W    = (STALL_N > 1) ? $clog2(STALL_N) : 1;
   localparam logic [SC_W-1:0] SC_LOAD = SC_W'(STALL_N - 1);

   state_e           state_q, state_d;
   logic [UPC_W-1:0] upc_q, upc_d;
   logic [UPC_W-1:0] tgt_q, tgt_d;
   logic [MI_W-1:0]  mi_q, mi_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [SC_W-1:0]  sc_q, sc_d;
   logic             use_carry_q, use_carry_d;

   seq_op_e          op;
   logic [MI_W-1:0]  cw_mi;
   logic [K_W-1:0]   cw_k;
   logic [UPC_W-1:0] k_tgt;
   logic [UPC_W-1:0] upc_inc;

   assign op      = cw_op(cs_data);
   assign cw_mi   = cs_data[CW_MI_LSB +: MI_W];
   assign cw_k    = cs_data[CW_K_LSB +: K_W];
   assign k_tgt   = cw_k[UPC_W-1:0];
   assign upc_inc = upc_q + UPC_W'(1);

`ifdef EV21G1_USTACK_EN
   logic             stk_push, stk_pop, stk_empty, stk_full;
   logic [UPC_W-1:0] stk_dout;

   ev21g1_ustack #(
      .W     (UPC_W),
      .DEPTH (USTACK_DEPTH)
   ) u_ustack (
      .clk   (clk),
      .reset (reset),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (upc_inc),
      .dout  (stk_dout),
      .empty (stk_empty),
      .full  (stk_full)
   );
`endif

   // Next-state, micro-PC and data-path word selection
   always_comb begin
      state_d     = state_q;
      upc_d       = upc_q;
      tgt_d       = tgt_q;
      use_carry_d = use_carry_q;
      sc_d        = sc_q;
      mi_d        = NOP_MI;
      k_d         = NOP_K;
`ifdef EV21G1_USTACK_EN
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_RUN;
               upc_d   = '0;
            end
         end
         ST_RUN: begin
            mi_d = cw_mi;
            k_d  = cw_k;
            case (op)
               OP_JUMP: upc_d = k_tgt;
               OP_JZ, OP_JC: begin
                  tgt_d       = k_tgt;
                  use_carry_d = (op == OP_JC);
                  sc_d        = SC_LOAD;
                  state_d     = ST_STALL;
               end
               OP_CALL: begin
                  upc_d = k_tgt;
`ifdef EV21G1_USTACK_EN
                  stk_push = 1'b1;
`endif
               end
               OP_RET: begin
`ifdef EV21G1_USTACK_EN
                  if (stk_empty) begin
                     state_d = ST_HALT;
                  end else begin
                     stk_pop = 1'b1;
                     upc_d   = stk_dout;
                  end
`else
                  upc_d = upc_inc;
`endif
               end
               OP_HALT: state_d = ST_HALT;
               default: upc_d = upc_inc;
            endcase
         end
         ST_STALL: begin
            // upc still holds the branch word's address, so upc+1 is the fall-through
            if (sc_q == '0) begin
               state_d = ST_RUN;
               upc_d   = (use_carry_q ? carry_flag : zero_flag) ? tgt_q : upc_inc;
            end else begin
               sc_d = sc_q - SC_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         upc_q       <= '0;
         tgt_q       <= '0;
         use_carry_q <= 1'b0;
         sc_q        <= '0;
         mi_q        <= NOP_MI;
         k_q         <= NOP_K;
      end else begin
         state_q     <= state_d;
         upc_q       <= upc_d;
         tgt_q       <= tgt_d;
         use_carry_q <= use_carry_d;
         sc_q        <= sc_d;
         mi_q        <= mi_d;
         k_q         <= k_d;
      end
   end

   assign cs_addr          = upc_q;
   assign microinstruction = mi_q;
   assign k                = k_q;
   assign halted           = (state_q == ST_HALT);

endmodule

// File: tb/tb_ev21g1_microsequencer.sv
// Bench for ev21g1_microsequencer. Each stimulus row drives the inputs for
// the coming clock edge and queues the outputs expected to be visible in the
// current cycle; a monitor on the falling edge pops and compares them.
`timescale 1ns/1ps
module tb_ev21g1_microsequencer;

   localparam logic [2:0]  OPC_CONT = 3'd0;
   localparam logic [2:0]  OPC_JUMP = 3'd1;
   localparam logic [2:0]  OPC_JZ   = 3'd2;
   localparam logic [2:0]  OPC_JC   = 3'd3;
   localparam logic [2:0]  OPC_CALL = 3'd4;
   localparam logic [2:0]  OPC_RET  = 3'd5;
   localparam logic [2:0]  OPC_HALT = 3'd6;
   localparam logic [29:0] NOP      = 30'h000000FC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        zero_flag = 1'b0;
   logic        carry_flag = 1'b0;
   logic [9:0]  cs_addr;
   logic [48:0] cs_data;
   logic [29:0] microinstruction;
   logic [15:0] k;
   logic        halted;

   logic [48:0] rom [0:1023];
   assign cs_data = rom[cs_addr];

   always #5 clk = ~clk;

   ev21g1_microsequencer #(.UPC_W(10), .STALL_N(3)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .cs_addr          (cs_addr),
      .cs_data          (cs_data),
      .zero_flag        (zero_flag),
      .carry_flag       (carry_flag),
      .microinstruction (microinstruction),
      .k                (k),
      .halted           (halted)
   );

   typedef struct {
      string       nm;
      logic [9:0]  a;
      logic [29:0] m;
      logic [15:0] kk;
      logic        h;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (cs_addr !== e.a || microinstruction !== e.m || k !== e.kk || halted !== e.h) begin
               bad++;
               $display("FAIL %s: got addr=%h mi=%h k=%h halted=%b, want addr=%h mi=%h k=%h halted=%b",
                        e.nm, cs_addr, microinstruction, k, halted, e.a, e.m, e.kk, e.h);
            end
         end
      end
   end

   function automatic logic [48:0] w(input logic [2:0] op, input logic [15:0] kk, input logic [29:0] m);
      return {op, kk, m};
   endfunction

   function automatic logic [29:0] mk(input int a);
      return 30'h1000 | 30'(a);
   endfunction

   task automatic rom_init();
      for (int i = 0; i < 1024; i++) rom[i] = w(OPC_CONT, 16'h0000, 30'(i + 1));
   endtask

   task automatic row(input logic r, input logic s, input logic z, input logic c, input string nm,
                      input logic [9:0] a, input logic [29:0] m, input logic [15:0] kk, input logic h);
      exp_t e;
      @(posedge clk);
      #1;
      reset      = r;
      start      = s;
      zero_flag  = z;
      carry_flag = c;
      e.nm = nm; e.a = a; e.m = m; e.kk = kk; e.h = h;
      exp_q.push_back(e);
   endtask

   task automatic reset_start();
      @(posedge clk);
      #1;
      reset = 1'b1; start = 1'b0; zero_flag = 1'b0; carry_flag = 1'b0;
      row(0, 1, 0, 0, "reset_state",    10'd0, NOP, 16'h0, 1'b0);
      row(0, 0, 0, 0, "start_from_idle", 10'd0, NOP, 16'h0, 1'b0);
   endtask

   // Default words: word i is CONT with mi = i+1, so address a shows mi = a
   task automatic seq_rows(input int from, input int to);
      for (int a = from; a <= to; a++) row(0, 0, 0, 0, "cont", 10'(a), 30'(a), 16'h0, 1'b0);
   endtask

   task automatic branch_test(input bit is_jc, input bit take, input string nm);
      logic sel_last, oth_last, sel_noise, oth_noise;
      rom_init();
      rom[8] = w(is_jc ? OPC_JC : OPC_JZ, 16'h0100, 30'h88);
      reset_start();
      seq_rows(1, 8);
      sel_noise = ~take; oth_noise = take;
      sel_last  = take;  oth_last  = ~take;
      row(0, 0, is_jc ? oth_noise : sel_noise, is_jc ? sel_noise : oth_noise, {nm, "_issue"},
          10'd8, 30'h88, 16'h0100, 1'b0);
      row(0, 0, is_jc ? oth_noise : sel_noise, is_jc ? sel_noise : oth_noise, {nm, "_nop1"},
          10'd8, NOP, 16'h0, 1'b0);
      row(0, 0, is_jc ? oth_last : sel_last, is_jc ? sel_last : oth_last, {nm, "_nop2"},
          10'd8, NOP, 16'h0, 1'b0);
      row(0, 0, 0, 0, {nm, "_nop3_resolve"}, take ? 10'h100 : 10'd9, NOP, 16'h0, 1'b0);
      row(0, 0, 0, 0, {nm, "_after"}, take ? 10'h101 : 10'd10, take ? 30'h101 : 30'd10, 16'h0, 1'b0);
   endtask

   initial begin
      rom_init();

      // Linear sequencing
      reset_start();
      seq_rows(1, 3);

      // Unconditional jump, k visible for exactly one cycle
      rom_init();
      rom[5] = w(OPC_JUMP, 16'h0040, 30'h55);
      reset_start();
      seq_rows(1, 5);
      row(0, 0, 0, 0, "jump_target", 10'h040, 30'h55, 16'h0040, 1'b0);
      row(0, 0, 0, 0, "jump_k_clear", 10'h041, 30'h41, 16'h0000, 1'b0);

      // Conditional branches
      branch_test(1'b0, 1'b1, "jz_taken");
      branch_test(1'b0, 1'b0, "jz_fall");
      branch_test(1'b1, 1'b1, "jc_taken");
      branch_test(1'b1, 1'b0, "jc_fall");

      // Halt, start ignored while running, restart from halt
      rom_init();
      rom[3] = w(OPC_HALT, 16'h0000, 30'h33);
      reset_start();
      row(0, 1, 0, 0, "run_ignore_start1", 10'd1, 30'd1, 16'h0, 1'b0);
      row(0, 1, 0, 0, "run_ignore_start2", 10'd2, 30'd2, 16'h0, 1'b0);
      row(0, 0, 0, 0, "pre_halt",          10'd3, 30'd3, 16'h0, 1'b0);
      row(0, 0, 0, 0, "halt_issue",        10'd3, 30'h33, 16'h0, 1'b1);
      row(0, 1, 0, 0, "halt_nop",          10'd3, NOP, 16'h0, 1'b1);
      row(0, 0, 0, 0, "restart",           10'd0, NOP, 16'h0, 1'b0);
      row(0, 0, 0, 0, "restart_run",       10'd1, 30'd1, 16'h0, 1'b0);

      // Reset in the middle of a stall must abandon the branch
      rom_init();
      rom[8] = w(OPC_JZ, 16'h0100, 30'h88);
      reset_start();
      seq_rows(1, 8);
      row(0, 0, 1, 0, "stall_issue",    10'd8, 30'h88, 16'h0100, 1'b0);
      row(1, 0, 1, 0, "stall_nop1",     10'd8, NOP, 16'h0, 1'b0);
      row(0, 0, 1, 0, "rst_in_stall",   10'd0, NOP, 16'h0, 1'b0);
      row(0, 0, 1, 0, "idle_after_rst", 10'd0, NOP, 16'h0, 1'b0);
      row(0, 0, 1, 0, "still_idle",     10'd0, NOP, 16'h0, 1'b0);

      // Micro-PC wrap from the top of the control store
      rom_init();
      rom[0] = w(OPC_JUMP, 16'h03FF, 30'hA0);
      reset_start();
      row(0, 0, 0, 0, "wrap_top",  10'h3FF, 30'hA0, 16'h03FF, 1'b0);
      row(0, 0, 0, 0, "wrap_zero", 10'h000, 30'h400, 16'h0000, 1'b0);

      // Single CALL/RET
      rom_init();
      rom[4]     = w(OPC_CALL, 16'h0200, 30'h44);
      rom[10'h200] = w(OPC_RET, 16'h0000, 30'h222);
      reset_start();
      seq_rows(1, 4);
      row(0, 0, 0, 0, "call", 10'h200, 30'h44, 16'h0200, 1'b0);
`ifdef EV21G1_USTACK_EN
      row(0, 0, 0, 0, "ret",       10'd5, 30'h222, 16'h0, 1'b0);
      row(0, 0, 0, 0, "after_ret", 10'd6, 30'd6, 16'h0, 1'b0);
`else
      row(0, 0, 0, 0, "ret_fall",       10'h201, 30'h222, 16'h0, 1'b0);
      row(0, 0, 0, 0, "after_ret_fall", 10'h202, 30'h202, 16'h0, 1'b0);
`endif

      // Five nested calls overflow the 4-deep stack; the fifth return halts
      rom_init();
      rom[0]     = w(OPC_CALL, 16'h0010, mk(0));
      rom[10'h10] = w(OPC_CALL, 16'h0020, mk(16'h10));
      rom[10'h20] = w(OPC_CALL, 16'h0030, mk(16'h20));
      rom[10'h30] = w(OPC_CALL, 16'h0040, mk(16'h30));
      rom[10'h40] = w(OPC_CALL, 16'h0050, mk(16'h40));
      rom[10'h50] = w(OPC_RET,  16'h0000, mk(16'h50));
      rom[10'h41] = w(OPC_RET,  16'h0000, mk(16'h41));
      rom[10'h31] = w(OPC_RET,  16'h0000, mk(16'h31));
      rom[10'h21] = w(OPC_RET,  16'h0000, mk(16'h21));
      rom[10'h11] = w(OPC_RET,  16'h0000, mk(16'h11));
      reset_start();
      row(0, 0, 0, 0, "nest_call1", 10'h10, mk(0),     16'h0010, 1'b0);
      row(0, 0, 0, 0, "nest_call2", 10'h20, mk(16'h10), 16'h0020, 1'b0);
      row(0, 0, 0, 0, "nest_call3", 10'h30, mk(16'h20), 16'h0030, 1'b0);
      row(0, 0, 0, 0, "nest_call4", 10'h40, mk(16'h30), 16'h0040, 1'b0);
      row(0, 0, 0, 0, "nest_call5", 10'h50, mk(16'h40), 16'h0050, 1'b0);
`ifdef EV21G1_USTACK_EN
      row(0, 0, 0, 0, "nest_ret1",      10'h41, mk(16'h50), 16'h0, 1'b0);
      row(0, 0, 0, 0, "nest_ret2",      10'h31, mk(16'h41), 16'h0, 1'b0);
      row(0, 0, 0, 0, "nest_ret3",      10'h21, mk(16'h31), 16'h0, 1'b0);
      row(0, 0, 0, 0, "nest_ret4",      10'h11, mk(16'h21), 16'h0, 1'b0);
      row(0, 0, 0, 0, "nest_ret5_halt", 10'h11, mk(16'h11), 16'h0, 1'b1);
      row(0, 0, 0, 0, "nest_halt_nop",  10'h11, NOP,        16'h0, 1'b1);
`else
      row(0, 0, 0, 0, "nest_ret_fall", 10'h51, mk(16'h50), 16'h0, 1'b0);
      row(0, 0, 0, 0, "nest_after",    10'h52, 30'h52,     16'h0, 1'b0);
`endif

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ev21g1_microsequencer.md
EV21G1_MICROSEQUENCER -- requirements
Module: ev21g1_microsequencer

Interface
REQ-001 SHALL have parameter UPC_W, default 10, micro-PC and control-store address width.
REQ-002 SHALL have parameter STALL_N, default 3, NOP bubbles inserted before a conditional branch resolves, matching the data-path writeback depth.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that launches the microprogram at address 0 from IDLE or HALT.
REQ-006 SHALL have port cs_addr  output  UPC_W  control-store address; combinational copy of upc.
REQ-007 SHALL have port cs_data  input  49  control-store word, valid the same cycle (asynchronous ROM): [48:46] seq op, [45:30] k, [29:0] microinstruction.
REQ-008 SHALL have port zero_flag  input  1  data-path zero flag.
REQ-009 SHALL have port carry_flag  input  1  data-path carry flag.
REQ-010 SHALL have port microinstruction  output  30  registered microinstruction to the data path.
REQ-011 SHALL have port k  output  16  registered constant to the data path.
REQ-012 SHALL have port halted  output  1  high in HALT state.

Function
REQ-013 SHALL encode seq op as CONT=0, JUMP=1, JZ=2, JC=3, CALL=4, RET=5, HALT=6; op 7 SHALL behave as CONT.
REQ-014 SHALL use NOP = 30'h000000FC (all fields 0, c=6'b111111) with k=0.
REQ-015 SHALL implement states IDLE, RUN, STALL, HALT.
REQ-016 In IDLE and HALT, SHALL emit NOP, hold upc, and on start go to RUN with upc=0.
REQ-017 In RUN, each cycle SHALL register cs_data[29:0] and cs_data[45:30] to the outputs (1-cycle latency from cs_addr).
REQ-018 CONT SHALL set upc=upc+1, wrapping 2^UPC_W-1 to 0.
REQ-019 JUMP SHALL set upc=k[UPC_W-1:0] of the current word.
REQ-020 JZ/JC SHALL issue their own microinstruction, latch target and op, enter STALL, and emit STALL_N NOPs.
REQ-021 On the last STALL cycle, SHALL sample the selected flag: if 1, upc=target, else upc=latched upc+1; then return to RUN.
REQ-022 HALT op SHALL issue its own microinstruction, enter HALT, and leave upc unchanged.
REQ-023 start while in RUN or STALL SHALL be ignored.
REQ-024 halted SHALL be 1 only in HALT.

Reset
REQ-025 reset SHALL force IDLE, upc=0, microinstruction=NOP, k=0, halted=0, stall counter=0 and stack empty, overriding start and any in-progress STALL.

Configuration
REQ-026 With EV21G1_USTACK_EN defined, CALL SHALL push upc+1 and jump to k[UPC_W-1:0], and RET SHALL pop into upc, using a 4-entry stack.
REQ-027 With EV21G1_USTACK_EN defined, a push when full SHALL overwrite the oldest entry (circular), and RET when empty SHALL behave as HALT.
REQ-028 Without EV21G1_USTACK_EN, CALL SHALL behave as JUMP, RET SHALL behave as CONT, and no stack storage SHALL be synthesized.

Structure
REQ-029 Package ev21g1_pkg SHALL hold the seq-op enum, the NOP constant, the field widths (microinstruction 30, k 16, control word 49) and the microinstruction field offsets.
REQ-030 The stack SHALL be sub-module ev21g1_ustack (push, pop, data in/out, empty, full), instantiated only under EV21G1_USTACK_EN.

Verification
REQ-031 Linear: reset, start, ROM words 0..2 CONT with microinstruction 0x1, 0x2, 0x3 -> outputs 0x1, 0x2, 0x3 on consecutive cycles, cs_addr 0,1,2,3.
REQ-032 Jump: word 5 = JUMP with k=0x0040 -> next cs_addr 0x040; k output = 0x0040 for one cycle.
REQ-033 Conditional branch, JZ at word 8 with target 0x100:
- zero_flag=1 at the third stall cycle -> three NOPs (0xFC), then cs_addr 0x100.
- zero_flag=0 -> three NOPs, then cs_addr 9.
- Repeat with JC and carry_flag.
REQ-034 Halt and restart:
- HALT at word 3 -> halted=1, NOP output, start ignored during RUN.
- start in HALT -> cs_addr 0.
- Reset during STALL -> IDLE, NOP, no branch taken.
REQ-035 Stack (macro on):
- CALL 0x200 from word 4, RET at 0x200 -> cs_addr 5.
- Five nested CALLs then five RETs -> fifth RET enters HALT.
- Macro off: CALL acts as a jump, RET falls through.
REQ-036 Wrap: upc=1023 with CONT -> next cs_addr 0.
